pt_check: RTL and testbench
===========================

PT_CHECK -- requirements
Module: pt_check

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse; begin checking a new candidate key.
REQ-004 cand_key  input  24  candidate key under test; sampled when start=1.
REQ-005 pt_wren  input  1  plaintext byte strobe from the decrypt stage.
REQ-006 pt_addr  input  8  plaintext byte index; index 0 is the message length L.
REQ-007 pt_wrdata  input  8  plaintext byte value.
REQ-008 busy  output  1  high from the start cycle until the verdict cycle.
REQ-009 checked  output  1  one-cycle pulse marking the verdict.
REQ-010 found  output  1  candidate accepted; sticky until the next start or rst.
REQ-011 resume  output  1  one-cycle pulse on reject; requests the next key.
REQ-012 key_out  output  24  captured cand_key; meaningful while found=1.
REQ-013 attempts  output  24  count of rejected candidates since rst.

Function
REQ-014 States: IDLE, LEN, SCAN, PASS, FAIL. start in any state SHALL go to LEN, capture cand_key, clear found, and set busy.
REQ-015 LEN: pt_wren with pt_addr=0 SHALL latch L=pt_wrdata and reset the expected index to 1; next state is SCAN, or PASS if L=0.
REQ-016 LEN: pt_wren with pt_addr!=0 SHALL go to FAIL (protocol error).
REQ-017 SCAN: each pt_wren SHALL require pt_addr equal to the expected index, else go to FAIL.
REQ-018 SCAN: a byte is printable iff 0x20 <= pt_wrdata <= 0x7E (inclusive); a non-printable byte SHALL go to FAIL.
REQ-019 SCAN: a printable byte with pt_addr=L SHALL go to PASS; otherwise the expected index increments.
REQ-020 Cycles without pt_wren SHALL hold state; there is no timeout.
REQ-021 PASS (one cycle): assert checked and set found; clear busy; return to IDLE.
REQ-022 FAIL (one cycle): assert checked and resume; clear busy; increment attempts, saturating at 0xFFFFFF; return to IDLE.
REQ-023 Verdict latency: checked SHALL be high exactly one cycle after the deciding pt_wren edge.
REQ-024 pt_wren in IDLE, PASS or FAIL SHALL be ignored.
REQ-025 start coinciding with pt_wren: start wins and the byte is discarded.
REQ-026 start while busy SHALL abort the current check; no checked pulse is issued and attempts is unchanged.
REQ-027 L=255: the index reaches 255 without wrap; the expected-index register is 8 bits.

Reset
REQ-028 rst SHALL force state IDLE and set busy=0, checked=0, found=0, resume=0, key_out=0, attempts=0, L=0, expected index=0.
REQ-029 rst mid-check SHALL discard the check with no output pulses; rst asserted for any duration is idempotent.

Structure
REQ-030 A shared package arc4_pkg SHALL hold KEY_W=24, PRINT_LO=8'h20, PRINT_HI=8'h7E and the pt_check state enum.
REQ-031 No sub-module is required; the printable test is an inline comparison.
REQ-032 Expected size is 120-200 lines of RTL, using one FSM and registered outputs.

Verification
REQ-033 start with key 0x000018; bytes addr0=3, then 'a','b','c' at addr1-3 -> checked and found one cycle after addr3; key_out=0x000018; attempts=0.
REQ-034 start with key 0x000016; addr0=4, addr1=0x41, addr2=0x1F -> checked and resume pulse one cycle after addr2; found=0; attempts=1.
REQ-035 Boundary bytes: L=2 with bytes 0x20 and 0x7E -> PASS; L=1 with byte 0x7F -> FAIL.
REQ-036 L=0 -> PASS one cycle after the addr0 write; out-of-order addr2 after addr0 -> FAIL.
REQ-037 Abort: start, L=5, two good bytes, then start with 0x000015 -> no checked pulse; the new check passes; key_out=0x000015.
REQ-038 rst pulse mid-SCAN -> all outputs 0 next cycle; a later pt_wren with no start is ignored.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 key-search plaintext checker:
// widths, the printable-ASCII window and the checker state encoding.
package arc4_pkg;
  localparam int unsigned KEY_W = 24;
  localparam int unsigned ATT_W = 24;
  localparam logic [7:0]  PRINT_LO = 8'h20;
  localparam logic [7:0]  PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_SCAN,
    ST_PASS,
    ST_FAIL
  } pt_state_e;
endpackage

// File: rtl/pt_check_if.sv
// Candidate/plaintext input bus and verdict outputs of pt_check.
interface pt_check_if;
  import arc4_pkg::*;

  logic             start;
  logic [KEY_W-1:0] cand_key;
  logic             pt_wren;
  logic [7:0]       pt_addr;
  logic [7:0]       pt_wrdata;
  logic             busy;
  logic             checked;
  logic             found;
  logic             resume;
  logic [KEY_W-1:0] key_out;
  logic [ATT_W-1:0] attempts;

  modport master (
    output start, cand_key, pt_wren, pt_addr, pt_wrdata,
    input  busy, checked, found, resume, key_out, attempts
  );

  modport slave (
    input  start, cand_key, pt_wren, pt_addr, pt_wrdata,
    output busy, checked, found, resume, key_out, attempts
  );
endinterface

// File: rtl/pt_check.sv
// Checks a decrypted message (length byte at index 0, then L bytes) for
// printable ASCII; accepts the candidate key or requests the next one.
module pt_check
  import arc4_pkg::*;
(
  input logic      clk,
  input logic      rst,
  pt_check_if.slave bus
);

  pt_state_e        state_q, state_d;
  logic             busy_q, busy_d;
  logic             checked_q, checked_d;
  logic             found_q, found_d;
  logic             resume_q, resume_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [ATT_W-1:0] attempts_q, attempts_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       idx_q, idx_d;

  logic printable;
  logic do_pass;
  logic do_fail;

  assign printable = (bus.pt_wrdata >= PRINT_LO) && (bus.pt_wrdata <= PRINT_HI);

  // Verdict outputs are registered on the deciding edge, so the PASS/FAIL
  // state cycle coincides with the checked pulse.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    checked_d  = 1'b0;
    resume_d   = 1'b0;
    found_d    = found_q;
    key_d      = key_q;
    attempts_d = attempts_q;
    len_d      = len_q;
    idx_d      = idx_q;
    do_pass    = 1'b0;
    do_fail    = 1'b0;

    if (bus.start) begin
      state_d = ST_LEN;
      key_d   = bus.cand_key;
      found_d = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_LEN: begin
          if (bus.pt_wren) begin
            if (bus.pt_addr == 8'd0) begin
              len_d = bus.pt_wrdata;
              idx_d = 8'd1;
              if (bus.pt_wrdata == 8'd0) do_pass = 1'b1;
              else                       state_d = ST_SCAN;
            end else begin
              do_fail = 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (bus.pt_wren) begin
            if ((bus.pt_addr != idx_q) || !printable) do_fail = 1'b1;
            else if (bus.pt_addr == len_q)           do_pass = 1'b1;
            else                                      idx_d = idx_q + 8'd1;
          end
        end
        ST_PASS, ST_FAIL: state_d = ST_IDLE;
        default:          state_d = ST_IDLE;
      endcase

      if (do_pass) begin
        state_d   = ST_PASS;
        checked_d = 1'b1;
        found_d   = 1'b1;
        busy_d    = 1'b0;
      end
      if (do_fail) begin
        state_d   = ST_FAIL;
        checked_d = 1'b1;
        resume_d  = 1'b1;
        busy_d    = 1'b0;
        if (attempts_q != '1) attempts_d = attempts_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      checked_q  <= 1'b0;
      found_q    <= 1'b0;
      resume_q   <= 1'b0;
      key_q      <= '0;
      attempts_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      checked_q  <= checked_d;
      found_q    <= found_d;
      resume_q   <= resume_d;
      key_q      <= key_d;
      attempts_q <= attempts_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.checked  = checked_q;
  assign bus.found    = found_q;
  assign bus.resume   = resume_q;
  assign bus.key_out  = key_q;
  assign bus.attempts = attempts_q;

endmodule

// File: tb/tb_pt_check.sv
// Directed-vector bench for pt_check with hand-computed expectations.
module tb_pt_check;
  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_bad;

  pt_check_if bus();

  pt_check u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.pt_wren   = 1'b1;
    bus.pt_addr   = addr;
    bus.pt_wrdata = data;
    step();
    bus.pt_wren   = 1'b0;
  endtask

  task automatic go(input logic [23:0] key);
    bus.start    = 1'b1;
    bus.cand_key = key;
    step();
    bus.start    = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_busy"},     32'(bus.busy),     32'd0);
    chk({tag, "_checked"},  32'(bus.checked),  32'd0);
    chk({tag, "_found"},    32'(bus.found),    32'd0);
    chk({tag, "_resume"},   32'(bus.resume),   32'd0);
    chk({tag, "_key"},      32'(bus.key_out),  32'd0);
    chk({tag, "_attempts"}, 32'(bus.attempts), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.start     = 1'b0;
    bus.cand_key  = '0;
    bus.pt_wren   = 1'b0;
    bus.pt_addr   = '0;
    bus.pt_wrdata = '0;
    rst = 1'b1;
    step();
    step();
    all_zero("reset");
    rst = 1'b0;
    step();

    // Accept: L=3, "abc"
    go(24'h000018);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wr(8'd0, 8'd3);
    wr(8'd1, 8'h61);
    wr(8'd2, 8'h62);
    chk("t1_early_checked", 32'(bus.checked), 32'd0);
    wr(8'd3, 8'h63);
    chk("t1_checked",  32'(bus.checked),  32'd1);
    chk("t1_found",    32'(bus.found),    32'd1);
    chk("t1_resume",   32'(bus.resume),   32'd0);
    chk("t1_busy_off", 32'(bus.busy),     32'd0);
    chk("t1_key",      32'(bus.key_out),  32'h000018);
    chk("t1_attempts", 32'(bus.attempts), 32'd0);
    step();
    chk("t1_pulse_end", 32'(bus.checked), 32'd0);
    chk("t1_sticky",    32'(bus.found),   32'd1);

    // Reject on 0x1F
    go(24'h000016);
    chk("t2_found_clr", 32'(bus.found), 32'd0);
    wr(8'd0, 8'd4);
    wr(8'd1, 8'h41);
    wr(8'd2, 8'h1F);
    chk("t2_checked",  32'(bus.checked),  32'd1);
    chk("t2_resume",   32'(bus.resume),   32'd1);
    chk("t2_found",    32'(bus.found),    32'd0);
    chk("t2_attempts", 32'(bus.attempts), 32'd1);
    step();
    chk("t2_resume_end", 32'(bus.resume), 32'd0);

    // Printable window edges
    go(24'h000001);
    wr(8'd0, 8'd2);
    wr(8'd1, 8'h20);
    wr(8'd2, 8'h7E);
    chk("t3_edge_found",  32'(bus.found),   32'd1);
    chk("t3_edge_checked", 32'(bus.checked), 32'd1);
    go(24'h000002);
    wr(8'd0, 8'd1);
    wr(8'd1, 8'h7F);
    chk("t3_7f_resume",   32'(bus.resume),   32'd1);
    chk("t3_7f_attempts", 32'(bus.attempts), 32'd2);

    // Empty message, out-of-order index, non-zero first address
    go(24'h000003);
    wr(8'd0, 8'd0);
    chk("t4_l0_checked", 32'(bus.checked), 32'd1);
    chk("t4_l0_found",   32'(bus.found),   32'd1);
    go(24'h000004);
    wr(8'd0, 8'd2);
    wr(8'd2, 8'h61);
    chk("t4_ooo_resume",   32'(bus.resume),   32'd1);
    chk("t4_ooo_attempts", 32'(bus.attempts), 32'd3);
    go(24'h000005);
    wr(8'd1, 8'h61);
    chk("t4_len_resume",   32'(bus.resume),   32'd1);
    chk("t4_len_attempts", 32'(bus.attempts), 32'd4);

    // Abort by restart, new key passes
    go(24'h000111);
    wr(8'd0, 8'd5);
    wr(8'd1, 8'h78);
    wr(8'd2, 8'h79);
    go(24'h000015);
    chk("t5_no_checked", 32'(bus.checked),  32'd0);
    chk("t5_attempts",   32'(bus.attempts), 32'd4);
    chk("t5_busy",       32'(bus.busy),     32'd1);
    wr(8'd0, 8'd1);
    wr(8'd1, 8'h7A);
    chk("t5_found", 32'(bus.found),   32'd1);
    chk("t5_key",   32'(bus.key_out), 32'h000015);

    // Start coinciding with a byte write discards the byte
    bus.pt_wren   = 1'b1;
    bus.pt_addr   = 8'd0;
    bus.pt_wrdata = 8'd0;
    go(24'h000006);
    bus.pt_wren = 1'b0;
    chk("t6_coincide_checked", 32'(bus.checked), 32'd0);
    chk("t6_coincide_busy",    32'(bus.busy),    32'd1);
    wr(8'd0, 8'd0);
    chk("t6_after_found", 32'(bus.found), 32'd1);

    // Asynchronous reset mid-scan
    go(24'h000033);
    wr(8'd0, 8'd3);
    wr(8'd1, 8'h61);
    #2 rst = 1'b1;
    #1;
    all_zero("t7_async");
    step();
    step();
    rst = 1'b0;
    step();
    wr(8'd0, 8'd1);
    wr(8'd1, 8'h61);
    all_zero("t7_ignored");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
